fetch_queue: RTL

Decoupling queue on the consumer side of the fetch interface: accepts {PC, instruction} pairs from the instruction-fetch stage and presents them in order to the decode stage. It drives `Freeze` back to fetch when full and discards all contents on a taken branch. It replaces the plain IF/ID register, so a decode-stage stall no longer forces fetch to stall on the same cycle.

---
 rtl/arm_pkg.sv | 27 ++
 rtl/fetch_queue_mem.sv | 42 ++++
 rtl/fetch_queue.sv | 130 +++++++++++++
 3 files changed

// File: rtl/arm_pkg.sv
// -----------------------------------------------------------------------------
// arm_pkg
// Definitions shared by the fetch, decode and execute stages.
//   ARM_DATA_W    : width of a PC and of an instruction word
//   FQ_DEPTH      : default number of entries in the fetch queue
//   fetch_entry_t : one queued fetch result, {pc, instr}
//   fq_pack       : builds a fetch_entry_t from a PC and an instruction
// -----------------------------------------------------------------------------
package arm_pkg;

  localparam int ARM_DATA_W = 32;
  localparam int FQ_DEPTH   = 4;

  typedef struct packed {
    logic [ARM_DATA_W-1:0] pc;
    logic [ARM_DATA_W-1:0] instr;
  } fetch_entry_t;

  function automatic fetch_entry_t fq_pack(input logic [ARM_DATA_W-1:0] pc,
                                           input logic [ARM_DATA_W-1:0] instr);
    fetch_entry_t ent;
    ent.pc    = pc;
    ent.instr = instr;
    return ent;
  endfunction

endpackage

// File: rtl/fetch_queue_mem.sv
// -----------------------------------------------------------------------------
// fetch_queue_mem
// DEPTH x WIDTH register array backing the fetch queue. One synchronous write
// port, one combinational read port. The array carries no reset: an entry is
// only meaningful while the owning queue's occupancy count covers it.
// Ports:
//   clk   in  rising-edge clock
//   we    in  write enable
//   waddr in  write address
//   wdata in  write data
//   raddr in  read address
//   rdata out read data (combinational from raddr)
// -----------------------------------------------------------------------------
module fetch_queue_mem
  import arm_pkg::*;
#(
  parameter int DEPTH = FQ_DEPTH,
  parameter int WIDTH = 2 * ARM_DATA_W
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem_r [DEPTH];

  // Write port: store the offered entry at the write address.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Read port: head entry is visible without a clock delay.
  always_comb begin
    rdata = mem_r[raddr];
  end

endmodule

// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
// Decoupling queue between instruction fetch and decode. Fetch pushes
// {PC, instruction} pairs; decode sees the oldest pair first-word-fall-through
// and pops it with ID_Ready. Freeze tells fetch to hold its PC while the queue
// is full; a taken branch (Flush) discards everything, including the pair
// offered on that cycle.
// Ports:
//   clk             in  rising-edge clock
//   rst             in  synchronous reset, active low
//   Fetch_Valid     in  fetch presents a valid pair
//   PC_in           in  fetch-stage PC
//   Instruction_in  in  instruction fetched at PC_in
//   Freeze          out queue full, fetch must hold and re-present its pair
//   Flush           in  taken branch, discard all entries
//   ID_Ready        in  decode accepts the head entry
//   ID_Valid        out head entry valid
//   PC_out          out head PC (0 when empty)
//   Instruction_out out head instruction (0 when empty)
//   Count           out occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module fetch_queue
  import arm_pkg::*;
#(
  parameter int DEPTH  = FQ_DEPTH,
  parameter int DATA_W = ARM_DATA_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     Fetch_Valid,
  input  logic [DATA_W-1:0]        PC_in,
  input  logic [DATA_W-1:0]        Instruction_in,
  output logic                     Freeze,
  input  logic                     Flush,
  input  logic                     ID_Ready,
  output logic                     ID_Valid,
  output logic [DATA_W-1:0]        PC_out,
  output logic [DATA_W-1:0]        Instruction_out,
  output logic [$clog2(DEPTH):0]   Count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = 2 * DATA_W;

  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ZERO  = {PTR_W{1'b0}};
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);

  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;

  logic             full_s;
  logic             empty_s;
  logic             push_s;
  logic             pop_s;
  logic             we_s;
  logic [ENT_W-1:0] wdata_s;
  logic [ENT_W-1:0] rdata_s;

  // Occupancy modes and the push/pop decisions, all from the registered count.
  // A push is refused while full even if decode pops in the same cycle: fetch
  // re-presents the held pair once Freeze drops, so nothing is lost.
  always_comb begin
    full_s  = (count_r == CNT_FULL);
    empty_s = (count_r == CNT_ZERO);
    push_s  = Fetch_Valid && !full_s && !Flush;
    pop_s   = !empty_s && ID_Ready && !Flush;
    // No writes while reset is held, so the array is left untouched.
    we_s    = push_s && rst;
    wdata_s = {PC_in, Instruction_in};
  end

  // Pointer and occupancy state; reset outranks Flush, Flush outranks traffic.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      count_r  <= CNT_ZERO;
    end else if (Flush) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      count_r  <= CNT_ZERO;
    end else begin
      // Pointers wrap naturally because DEPTH is a power of two.
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  fetch_queue_mem #(
    .DEPTH (DEPTH),
    .WIDTH (ENT_W)
  ) u_mem (
    .clk   (clk),
    .we    (we_s),
    .waddr (wr_ptr_r),
    .wdata (wdata_s),
    .raddr (rd_ptr_r),
    .rdata (rdata_s)
  );

  // Decode-side view: head entry fall-through, zeroed when the queue is empty
  // so stale array contents never leak to decode.
  always_comb begin
    Freeze   = full_s;
    ID_Valid = !empty_s;
    Count    = count_r;
    if (empty_s) begin
      PC_out          = {DATA_W{1'b0}};
      Instruction_out = {DATA_W{1'b0}};
    end else begin
      PC_out          = rdata_s[ENT_W-1:DATA_W];
      Instruction_out = rdata_s[DATA_W-1:0];
    end
  end

endmodule
